// File: rtl/dsram_like_slave_if.sv
// rtl/dsram_like_slave_if.sv - sram-like data request/response bundle
//
// Ports (signals):
//   data_sram_en     request valid, held by the requester until addr_ok
//   data_sram_we     byte-lane write enables, 0 means read
//   data_sram_addr   byte address
//   data_sram_wdata  write data, lane-replicated by the requester
//   addr_ok          request accepted when data_sram_en is also high
//   data_ok          one-cycle completion pulse, oldest request first
//   data_sram_rdata  read data, valid while data_ok is high
interface dsram_like_slave_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
      input  addr_ok, data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
      output addr_ok, data_ok, data_sram_rdata
   );
endinterface

// File: rtl/dsram_like_slave.sv
// rtl/dsram_like_slave.sv - sram-like data responder with fixed-latency in-order completions
//
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    dsram_like_slave_if.slave: request in (en/we/addr/wdata),
//          addr_ok grant, data_ok completion pulse with data_sram_rdata
module dsram_like_slave #(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2,
   parameter int QDEPTH     = 4,
   parameter bit RAND_STALL = 1'b0
) (
   input logic               clk,
   input logic               reset,
   dsram_like_slave_if.slave bus
);
   localparam int            PW       = $clog2(QDEPTH);
   localparam int            DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0]    CNT_INIT = 4'(LATENCY - 1);
   localparam logic [PW:0]   QD_FULL  = QDEPTH[PW:0];
   localparam logic [PW:0]   CNT_ONE  = 1;
   localparam logic [PW-1:0] PTR_ONE  = 1;

   logic [31:0]           mem    [DEPTH];
   logic [31:0]           q_data [QDEPTH];
   logic [3:0]            q_cnt  [QDEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW:0]           count;
   logic [7:0]            lfsr;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  accept;
   logic                  pop;
   logic                  stall;
   logic                  unused_addr_bits;

   // Byte offset and bits above the memory size are dropped, so addresses alias.
   assign idx              = bus.data_sram_addr[ADDR_WIDTH+1:2];
   assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_WIDTH+2], bus.data_sram_addr[1:0]};

   // Grant depends only on the registered count: a pop never frees a slot in
   // the same cycle, which keeps addr_ok off any path from the queue head.
   assign stall       = RAND_STALL && lfsr[0];
   assign bus.addr_ok = !reset && (count < QD_FULL) && !stall;
   assign accept      = bus.data_sram_en && bus.addr_ok;

   // Head completes once its countdown reaches zero; there is no backpressure.
   assign pop                 = !reset && (count != '0) && (q_cnt[rd_ptr] == 4'd0);
   assign bus.data_ok         = pop;
   assign bus.data_sram_rdata = pop ? q_data[rd_ptr] : 32'b0;

   // Memory contents survive reset; accept already excludes reset cycles.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.data_sram_we[i]) begin
               mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_cnt[i] <= 4'd0;
         end
      end else begin
         // Free slots may tick too; their count is rewritten on the next accept.
         for (int i = 0; i < QDEPTH; i++) begin
            if (q_cnt[i] != 4'd0) begin
               q_cnt[i] <= q_cnt[i] - 4'd1;
            end
         end
         if (accept) begin
            q_cnt[wr_ptr]  <= CNT_INIT;
            // Read captures the pre-edge word, which already holds every earlier write.
            q_data[wr_ptr] <= (bus.data_sram_we == 4'b0000) ? mem[idx] : 32'b0;
            wr_ptr         <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({accept, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end
endmodule
